// File: rtl/src_buf_pingpong_pkg.sv
// Shared defaults and helpers for the ping-pong source buffer.
// Slot order for flattened read buses is b*N_PORT+p.
package src_buf_pingpong_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int slot_idx(
    input int b,
    input int p,
    input int n_port
  );
    return b * n_port + p;
  endfunction

  localparam int N_BANK_D = 6;
  localparam int N_PORT_D = 5;
  localparam int DATA_W_D = 16;
  localparam int DEPTH_D  = 256;
  localparam int ADDR_W_D = clog2(DEPTH_D);
  localparam int BANK_W_D = 8;

endpackage

// File: rtl/src_buf_bank.sv
// One channel bank: two pages, one write port,
// N_PORT registered read ports sharing a page select.
module src_buf_bank
  import src_buf_pingpong_pkg::*;
#(
  parameter int N_PORT = N_PORT_D,
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     wr_page,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     re,
  input  logic                     rd_page,
  input  logic [N_PORT*ADDR_W-1:0] rd_addr,
  output logic [N_PORT*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][DEPTH];

  // Page storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_page][wr_addr] <= wr_data;
    end
  end

  // Registered reads, one per port, all from the same page.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      for (int p = 0; p < N_PORT; p++) begin
        rd_data[p*DATA_W +: DATA_W] <=
          mem[rd_page][rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: rtl/src_buf_pingpong.sv
// Double-buffered source feature-map buffer.
// Loader fills one page while the conv engine reads the other.
module src_buf_pingpong
  import src_buf_pingpong_pkg::*;
#(
  parameter int N_BANK = N_BANK_D,
  parameter int N_PORT = N_PORT_D,
  parameter int DATA_W = DATA_W_D,
  parameter int DEPTH  = DEPTH_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int BANK_W = BANK_W_D
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [BANK_W-1:0]               wr_bank,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            wr_last,
  input  logic                            rd_en,
  input  logic [N_BANK*N_PORT*ADDR_W-1:0] rd_addr,
  output logic [N_BANK*N_PORT*DATA_W-1:0] rd_data,
  output logic                            rd_valid,
  output logic                            rd_page_valid,
  input  logic                            rd_release,
  output logic [1:0]                      pages_full,
  output logic                            err_bank
);

  localparam int PA = N_PORT * ADDR_W;
  localparam int PD = N_PORT * DATA_W;

  logic [1:0] full;
  logic       wr_sel;
  logic       rd_sel;
  logic       acc;
  logic       wr_fin;
  logic       bank_bad;
  logic       rd_fire;
  logic       rel;

  assign wr_ready      = !full[wr_sel];
  assign acc           = wr_valid && wr_ready;
  assign wr_fin        = acc && wr_last;
  assign bank_bad      = wr_bank >= BANK_W'(N_BANK);
  assign rd_page_valid = full[rd_sel];
  assign rd_fire       = rd_en && rd_page_valid;
  assign rel           = rd_release && rd_page_valid;
  assign pages_full    = {1'b0, full[0]} + {1'b0, full[1]};

  // Page ownership: a finished load and a release always hit
  // different pages, so both updates may apply together.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (wr_fin) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= !wr_sel;
      end
      if (rel) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
      end
    end
  end

  // Read-result flag and sticky out-of-range bank flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      err_bank <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (acc && bank_bad) begin
        err_bank <= 1'b1;
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    localparam int S0 = slot_idx(b, 0, N_PORT);
    logic we_b;
    assign we_b = acc && (wr_bank == BANK_W'(b));

    src_buf_bank #(
      .N_PORT (N_PORT),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (we_b),
      .wr_page (wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .re      (rd_fire),
      .rd_page (rd_sel),
      .rd_addr (rd_addr[S0*ADDR_W +: PA]),
      .rd_data (rd_data[S0*DATA_W +: PD])
    );
  end

endmodule

// File: doc/src_buf_pingpong.md
Name: src_buf_pingpong

Overview:
- Parametrised, double-buffered source feature-map buffer for convolution layers.
- N_BANK banks (one per input channel), each with N_PORT independent read ports.
- Two pages per bank: a loader fills one page through a single valid/ready write port while the conv engine reads the other.
- Page ownership moves by frame-level handshake (wr_last / rd_release). Successor to the fixed 6-bank, 5-port, single-page source buffer.

Parameters:
- N_BANK, 6, number of channel banks
- N_PORT, 5, read ports per bank
- DATA_W, 16, word width
- DEPTH, 256, words per page per bank
- ADDR_W, 8, word address width; must equal clog2(DEPTH)
- BANK_W, 8, width of bank-select field

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- wr_valid  in  1  write word offered
- wr_ready  out  1  write page free to accept data
- wr_bank  in  BANK_W  target bank index
- wr_addr  in  ADDR_W  word address within page
- wr_data  in  DATA_W  write word
- wr_last  in  1  last word of the frame load; qualified by wr_valid&&wr_ready
- rd_en  in  1  read strobe, common to all ports
- rd_addr  in  N_BANK*N_PORT*ADDR_W  flattened; slot (b*N_PORT+p)
- rd_data  out  N_BANK*N_PORT*DATA_W  flattened; same slot order
- rd_valid  out  1  rd_data holds a valid read result
- rd_page_valid  out  1  read page holds a complete frame
- rd_release  in  1  consumer frees read page
- pages_full  out  2  number of full pages (0..2)
- err_bank  out  1  sticky: write to bank >= N_BANK seen

Behaviour:
- State: full[1:0], wr_sel, rd_sel. Reset: full=0, wr_sel=0, rd_sel=0, rd_valid=0, rd_data=0, err_bank=0. Memory contents are not reset.
- Write path:
  - wr_ready = !full[wr_sel] (combinational).
  - Accept = wr_valid && wr_ready. On accept, mem[wr_bank][wr_sel][wr_addr] <= wr_data.
  - wr_bank >= N_BANK: word is accepted and dropped; err_bank <= 1 until rst.
  - Accept with wr_last: full[wr_sel] <= 1 and wr_sel toggles. The last word is still written.
  - wr_valid while !wr_ready: nothing is written; the source holds the word.
- Read path:
  - rd_page_valid = full[rd_sel].
  - rd_en && rd_page_valid: every slot is read from page rd_sel (value sampled this cycle). rd_data is registered, so data appears next cycle with rd_valid=1.
  - rd_en while !rd_page_valid: rd_valid=0 next cycle and rd_data holds its previous value.
  - All N_BANK*N_PORT reads are independent; duplicate addresses are allowed.
  - Read latency is exactly 1 cycle; back-to-back rd_en gives one result per cycle.
- Release: rd_release && rd_page_valid sets full[rd_sel] <= 0 and toggles rd_sel. rd_release while !rd_page_valid is ignored.
- Simultaneous events:
  - rd_en and rd_release in the same cycle: the read uses the old page; the released page returns its data next cycle.
  - Final write (wr_last) and rd_release in the same cycle always target different pages, so both take effect.
  - A write to the read page is impossible while that page is full.
  - A write and a read of the same address on different pages never interfere.
- Address wrap: wr_addr and rd_addr are ADDR_W bits and index 0..DEPTH-1 directly; there is no wrap logic.
- pages_full = full[0] + full[1].
- Reset mid-frame: a partially loaded page is discarded (full=0). rd_valid drops the cycle after rst is sampled.

Decomposition:
- Shared package/header: default parameter values, clog2 function, and the slot index macro b*N_PORT+p.
- Sub-module src_buf_bank: one bank with two pages, one write port (we, page, addr, data), and N_PORT registered read ports with a page select.
- Top level holds the page-control state, bank decode, error flag, and generate loop over banks.

Test Plan:
- Reset, then fill page 0 with bank b word a = b*256+a, wr_last at b=5, a=255 -> wr_ready=0 only if page 1 is also full; here rd_page_valid=1 and pages_full=1.
- rd_en with every slot at address 10 -> next cycle bank b returns b*256+10 on all 5 ports, rd_valid=1.
- Load page 1 with value 0xA000+a while reading page 0 -> page 0 data unchanged. After the page 1 load, pages_full=2 and wr_ready=0; a held wr_valid writes nothing.
- rd_release and rd_en same cycle, address 3 -> returns page 0 value b*256+3. Following rd_en returns 0xA003 and pages_full=1.
- Write to wr_bank=7 -> err_bank=1, all bank contents unchanged, flag persists until rst.
- Assert rst during a partial load -> pages_full=0, rd_valid=0, wr_ready=1 next cycle. rd_en with no loaded page gives rd_valid=0.
